// File: rtl/dbg_clk_pkg.sv
// Shared types for the debug clock controller.
package dbg_clk_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    RESUME = 2'd2,
    STEP   = 2'd3
  } dbg_state_t;

  typedef enum logic [1:0] {
    NONE      = 2'd0,
    BREAK     = 2'd1,
    REQ       = 2'd2,
    STEP_DONE = 2'd3
  } halt_cause_t;

endpackage

// File: rtl/dbg_step_counter.sv
// Loadable down-counter that tracks the enabled cycles left in a debug step.
module dbg_step_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             is_one
);

  logic [CNT_W-1:0] cnt_q;

  // Clear beats load, load beats decrement; never decrement past zero.
  always_ff @(posedge clk) begin
    if (!reset)                   cnt_q <= '0;
    else if (clr)                 cnt_q <= '0;
    else if (load)                cnt_q <= load_val;
    else if (dec && cnt_q != '0)  cnt_q <= cnt_q - 1'b1;
  end

  assign value  = cnt_q;
  assign is_one = (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/dbg_clk_ctrl.sv
// Debug clock controller: run / halt / N-cycle step control of the core
// clock enable, continue pulse to the breakpoint unit, enabled-cycle count.
module dbg_clk_ctrl
  import dbg_clk_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int CYC_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stop_clk,
  input  logic             halt_req,
  input  logic             run_req,
  input  logic             step_req,
  input  logic [CNT_W-1:0] step_n,
  input  logic             cyc_clr,
  output logic             clk_en,
  output logic             break_continue,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CYC_W-1:0] cyc_count
);

  dbg_state_t       state_q, state_d;
  halt_cause_t      cause_q, cause_d;
  logic             rts_q, rts_d;
  logic [CYC_W-1:0] cyc_q;

  logic             cnt_clr, cnt_load, cnt_dec, cnt_is_one;
  logic [CNT_W-1:0] cnt_value;
  logic             run_like;

  dbg_step_counter #(.CNT_W(CNT_W)) u_step_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (step_n),
    .dec      (cnt_dec),
    .value    (cnt_value),
    .is_one   (cnt_is_one)
  );

  // While reset is held the state register may not yet show RUN, so the
  // outputs are forced to their reset-time values directly.
  assign run_like       = (state_q == RUN) || (state_q == STEP);
  assign clk_en         = !reset ? !stop_clk : (run_like && !stop_clk);
  assign break_continue = reset && (state_q == RESUME);
  assign halted         = reset && (state_q == HALTED);
  assign halt_cause     = cause_q;
  assign cyc_count      = cyc_q;

  // State, halt cause and step/run selection registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      cause_q <= NONE;
      rts_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      rts_q   <= rts_d;
    end
  end

  // Next-state logic and step counter control.
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    rts_d    = rts_q;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (stop_clk) begin
          state_d = HALTED;
          cause_d = BREAK;
        end else if (halt_req) begin
          state_d = HALTED;
          cause_d = REQ;
        end
      end
      HALTED: begin
        if (run_req) begin
          state_d = RESUME;
          rts_d   = 1'b0;
        end else if (step_req && step_n != '0) begin
          state_d  = RESUME;
          rts_d    = 1'b1;
          cnt_load = 1'b1;
        end
      end
      RESUME: begin
        cause_d = NONE;
        state_d = rts_q ? STEP : RUN;
      end
      STEP: begin
        if (stop_clk) begin
          state_d = HALTED;
          cause_d = BREAK;
          cnt_clr = 1'b1;
        end else if (halt_req) begin
          state_d = HALTED;
          cause_d = REQ;
          cnt_clr = 1'b1;
        end else if (cnt_is_one) begin
          // stop_clk is low here, so this is the last enabled cycle.
          state_d = HALTED;
          cause_d = STEP_DONE;
          cnt_clr = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        cause_d = NONE;
      end
    endcase
  end

  // Enabled-cycle counter; clear wins over increment, wraps naturally.
  always_ff @(posedge clk) begin
    if (!reset)       cyc_q <= '0;
    else if (cyc_clr) cyc_q <= '0;
    else if (clk_en)  cyc_q <= cyc_q + 1'b1;
  end

endmodule
